// File: rtl/nexys_starship_scoreboard.sv
// Scoreboard for the starship game: BCD repair score and survival seconds,
// freeze on game over, 8-digit seven-segment scan. Optional: NEXYS_STARSHIP_HISCORE_EN.
module nexys_starship_scoreboard #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_SHIFT = 14
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic        play_flag,
  input  logic        gameover_ctrl,
  input  logic [3:0]  repair_pulse,
  output logic [15:0] score,
  output logic [15:0] seconds,
  output logic        frozen,
  output logic [7:0]  an,
  output logic [7:0]  cathodes
`ifdef NEXYS_STARSHIP_HISCORE_EN
  ,
  output logic [15:0] hiscore
`endif
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam int unsigned SCAN_W = SCAN_SHIFT + 3;

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_DASH  = 8'b1111_1101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t             state, next_state;
  logic               start, count_en, freeze;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick_wrap;
  logic               played;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [2:0]         pulse_cnt;
  logic [15:0]        upper_group;
  logic [15:0]        group;
  logic [1:0]         pos;
  logic [3:0]         digit;
  logic               blank;
  logic [7:0]         an_next;
  logic [7:0]         cathodes_next;

  // Adds inc (0..4) to a 4-digit BCD value with ripple carry; saturates at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [2:0] inc);
    logic [4:0]  d;
    logic [2:0]  c;
    logic [15:0] r;
    c = inc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, v[4*i +: 4]} + {2'b00, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 3'd1;
      end else begin
        c = 3'd0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return (c != 3'd0) ? 16'h9999 : r;
  endfunction

  // Active-low abcdefg segment table.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b000_0001;
      4'h1: s = 7'b100_1111;
      4'h2: s = 7'b001_0010;
      4'h3: s = 7'b000_0110;
      4'h4: s = 7'b100_1100;
      4'h5: s = 7'b010_0100;
      4'h6: s = 7'b010_0000;
      4'h7: s = 7'b000_1111;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b000_0100;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b110_0000;
      4'hC: s = 7'b011_0001;
      4'hD: s = 7'b100_0010;
      4'hE: s = 7'b011_0000;
      4'hF: s = 7'b011_1000;
    endcase
    return s;
  endfunction

  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // pre-edge values; Reset is in the sensitivity list because it is asynchronous.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    count_en   = 1'b0;
    freeze     = 1'b0;
    unique case (state)
      IDLE: begin
        if (play_flag && !gameover_ctrl) begin
          next_state = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (gameover_ctrl) begin
          next_state = FROZEN;
          freeze     = 1'b1;
        end else begin
          count_en = 1'b1;
          if (!play_flag) next_state = IDLE;
        end
      end
      FROZEN: begin
        if (!play_flag && !gameover_ctrl) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign frozen    = (state == FROZEN);
  assign tick_wrap = count_en && (tick_cnt == TICK_LAST);
  assign pulse_cnt = {2'b00, repair_pulse[0]} + {2'b00, repair_pulse[1]}
                   + {2'b00, repair_pulse[2]} + {2'b00, repair_pulse[3]};

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
      score    <= '0;
      seconds  <= '0;
      played   <= 1'b0;
    end else if (start) begin
      tick_cnt <= '0;
      score    <= '0;
      seconds  <= '0;
      played   <= 1'b1;
    end else if (count_en) begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      score    <= bcd_add_sat(score, pulse_cnt);
      if (tick_wrap) seconds <= bcd_add_sat(seconds, 3'd1);
    end
  end

`ifdef NEXYS_STARSHIP_HISCORE_EN
  // Packed valid BCD orders the same as its binary value, so a plain compare works.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)                         hiscore <= '0;
    else if (freeze && score > hiscore) hiscore <= score;
  end

  assign upper_group = (state == FROZEN) ? hiscore : seconds;
`else
  assign upper_group = seconds;
`endif

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) scan_cnt <= '0;
    else       scan_cnt <= scan_cnt + 1'b1;
  end

  assign idx   = scan_cnt[SCAN_SHIFT+2:SCAN_SHIFT];
  assign group = idx[2] ? upper_group : score;
  assign pos   = idx[1:0];
  assign digit = group[{pos, 2'b00} +: 4];

  // A digit blanks when it and every higher digit of its group are zero.
  always_comb begin
    blank = 1'b0;
    unique case (pos)
      2'd3: blank = (group[15:12] == 4'd0);
      2'd2: blank = (group[15:8]  == 8'd0);
      2'd1: blank = (group[15:4]  == 12'd0);
      2'd0: blank = 1'b0;
    endcase
  end

  always_comb begin
    an_next = ~(8'h01 << idx);
    if (state == IDLE && !played)
      cathodes_next = GLYPH_DASH;
    else if (blank)
      cathodes_next = GLYPH_BLANK;
    else
      cathodes_next = {seg7(digit), ~(state == FROZEN && idx == 3'd0)};
  end

  // Anode and cathode share one register stage so they always switch together.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      an       <= 8'hFF;
      cathodes <= 8'hFF;
    end else begin
      an       <= an_next;
      cathodes <= cathodes_next;
    end
  end

endmodule

// File: tb/tb_nexys_starship_scoreboard.sv
// Directed self-checking bench for nexys_starship_scoreboard (fast tick and scan).
module tb_nexys_starship_scoreboard;

  localparam int TICK_DIV   = 10;
  localparam int SCAN_SHIFT = 2;
  localparam int DIG_CYC    = 1 << SCAN_SHIFT;

  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_DASH  = 8'b1111_1101;
  localparam logic [7:0] G0      = 8'b0000_0011;
  localparam logic [7:0] G2      = 8'b0010_0101;
  localparam logic [7:0] G3      = 8'b0000_1101;
  localparam logic [7:0] G5      = 8'b0100_1001;
  localparam logic [7:0] G6      = 8'b0100_0001;
  localparam logic [7:0] G6_DP   = 8'b0100_0000;
  localparam logic [7:0] G9      = 8'b0000_1001;
  localparam logic [7:0] G9_DP   = 8'b0000_1000;

  logic        board_clk = 1'b0;
  logic        Reset;
  logic        play_flag;
  logic        gameover_ctrl;
  logic [3:0]  repair_pulse;
  logic [15:0] score;
  logic [15:0] seconds;
  logic        frozen;
  logic [7:0]  an;
  logic [7:0]  cathodes;
`ifdef NEXYS_STARSHIP_HISCORE_EN
  logic [15:0] hiscore;
`endif

  int errors = 0;
  int checks = 0;

  nexys_starship_scoreboard #(
    .TICK_DIV   (TICK_DIV),
    .SCAN_SHIFT (SCAN_SHIFT)
  ) dut (
    .board_clk     (board_clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .repair_pulse  (repair_pulse),
    .score         (score),
    .seconds       (seconds),
    .frozen        (frozen),
    .an            (an),
    .cathodes      (cathodes)
`ifdef NEXYS_STARSHIP_HISCORE_EN
    ,
    .hiscore       (hiscore)
`endif
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  // Aligns to the start of digit 0, then walks all eight digit periods.
  task automatic sweep(input string tag, input logic [7:0][7:0] glyphs);
    int n;
    logic [7:0] pat;
    n = 0;
    while (an !== 8'h7F && n < 100) begin step(1); n++; end
    check({tag, "_sync7"}, an, 8'h7F);
    n = 0;
    while (an !== 8'hFE && n < 100) begin step(1); n++; end
    check({tag, "_sync0"}, an, 8'hFE);
    for (int i = 0; i < 8; i++) begin
      pat = ~(8'h01 << i);
      check($sformatf("%s_an%0d", tag, i), an, pat);
      check($sformatf("%s_cath%0d", tag, i), cathodes, glyphs[i]);
      n = 0;
      while (an === pat && n < 20) begin step(1); n++; end
      check($sformatf("%s_len%0d", tag, i), n, DIG_CYC);
    end
  endtask

  initial begin
    Reset         = 1'b1;
    play_flag     = 1'b0;
    gameover_ctrl = 1'b0;
    repair_pulse  = 4'b0000;
    #12;
    check("rst_score", score, 16'h0000);
    check("rst_seconds", seconds, 16'h0000);
    check("rst_frozen", frozen, 1'b0);
    check("rst_an", an, 8'hFF);
    check("rst_cath", cathodes, 8'hFF);
    @(negedge board_clk);
    Reset = 1'b0;
    step(3);
    check("idle_dash", cathodes, G_DASH);
    check("idle_onehot", 32'($countones(~an)), 1);

    // Game 1: 35 cycles of survival, two repairs, then game over.
    play_flag = 1'b1;
    step(1);
    step(35);
    check("g1_seconds35", seconds, 16'h0003);
    check("g1_score35", score, 16'h0000);
    repair_pulse = 4'b1111;
    step(1);
    check("g1_score4", score, 16'h0004);
    repair_pulse = 4'b0101;
    step(1);
    check("g1_score6", score, 16'h0006);
    repair_pulse  = 4'b0001;
    gameover_ctrl = 1'b1;
    step(1);
    repair_pulse = 4'b0000;
    check("g1_over_score", score, 16'h0006);
    check("g1_over_frozen", frozen, 1'b1);
    check("g1_over_seconds", seconds, 16'h0003);
`ifdef NEXYS_STARSHIP_HISCORE_EN
    check("g1_hiscore", hiscore, 16'h0006);
`endif
    step(30);
    check("g1_hold_seconds", seconds, 16'h0003);
    check("g1_hold_score", score, 16'h0006);
`ifdef NEXYS_STARSHIP_HISCORE_EN
    sweep("g1_scan", {G_BLANK, G_BLANK, G_BLANK, G6, G_BLANK, G_BLANK, G_BLANK, G6_DP});
`else
    sweep("g1_scan", {G_BLANK, G_BLANK, G_BLANK, G3, G_BLANK, G_BLANK, G_BLANK, G6_DP});
`endif
    play_flag     = 1'b0;
    gameover_ctrl = 1'b0;
    step(1);
    check("g1_idle_frozen", frozen, 1'b0);
    check("g1_idle_score", score, 16'h0006);

    // Game 2: restart clears, then climb to saturation.
    play_flag = 1'b1;
    step(1);
    check("g2_clr_score", score, 16'h0000);
    check("g2_clr_seconds", seconds, 16'h0000);
`ifdef NEXYS_STARSHIP_HISCORE_EN
    check("g2_hiscore_kept", hiscore, 16'h0006);
`endif
    repair_pulse = 4'b1111;
    step(25);
    check("g2_score100", score, 16'h0100);
    step(2474);
    repair_pulse = 4'b0011;
    step(1);
    check("g2_score9998", score, 16'h9998);
    repair_pulse = 4'b0111;
    step(1);
    check("g2_sat", score, 16'h9999);
    repair_pulse = 4'b1111;
    step(1);
    check("g2_sat_hold", score, 16'h9999);
    repair_pulse = 4'b0000;
    check("g2_seconds", seconds, 16'h0250);
    gameover_ctrl = 1'b1;
    step(1);
    check("g2_frozen", frozen, 1'b1);
`ifdef NEXYS_STARSHIP_HISCORE_EN
    check("g2_hiscore", hiscore, 16'h9999);
    sweep("g2_scan", {G9, G9, G9, G9, G9, G9, G9, G9_DP});
`else
    sweep("g2_scan", {G_BLANK, G2, G5, G0, G9, G9, G9, G9_DP});
`endif
    play_flag     = 1'b0;
    gameover_ctrl = 1'b0;
    step(1);

    // Game 3: asynchronous reset mid-game.
    play_flag = 1'b1;
    step(1);
    repair_pulse = 4'b1111;
    step(3);
    repair_pulse = 4'b0000;
    check("g3_score12", score, 16'h0012);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_score", score, 16'h0000);
    check("arst_seconds", seconds, 16'h0000);
    check("arst_frozen", frozen, 1'b0);
    check("arst_an", an, 8'hFF);
    check("arst_cath", cathodes, 8'hFF);
`ifdef NEXYS_STARSHIP_HISCORE_EN
    check("arst_hiscore", hiscore, 16'h0000);
`endif
    play_flag = 1'b0;
    @(negedge board_clk);
    Reset = 1'b0;
    step(2);
    check("arst_dash", cathodes, G_DASH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
